// File: rtl/ahb_lite_uart_tx_feeder.sv
// rtl/ahb_lite_uart_tx_feeder.sv - AHB-Lite master feeding a UART16550 THR from a byte FIFO (optional init: UART_FEEDER_INIT_EN)
module ahb_lite_uart_tx_feeder #(
    parameter logic [31:0] UART_BASE  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          BURST_MAX  = 16,
    parameter logic [15:0] DIVISOR    = 16'd27,
    localparam int         AW         = $clog2(FIFO_DEPTH),
    localparam int         LW         = AW + 1,
    localparam int         CW         = $clog2(BURST_MAX) + 1
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic [31:0]   HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic [3:0]    HPROT,
    output logic          HMASTLOCK,
    output logic [31:0]   HWDATA,
    input  logic [31:0]   HRDATA,
    input  logic          HREADY,
    input  logic          HRESP,
    output logic [LW-1:0] fifo_level,
    output logic          busy,
    output logic          err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_POLL_A = 3'd1;
    localparam logic [2:0] S_POLL_D = 3'd2;
    localparam logic [2:0] S_WR_A   = 3'd3;
    localparam logic [2:0] S_WR_D   = 3'd4;
`ifdef UART_FEEDER_INIT_EN
    localparam logic [2:0] S_BOOT   = 3'd5;
    localparam logic [2:0] S_INIT_A = 3'd6;
    localparam logic [2:0] S_INIT_D = 3'd7;
    localparam logic [2:0] S_RESET  = S_BOOT;
`else
    localparam logic [2:0] S_RESET  = S_IDLE;
`endif

    localparam logic [31:0] OFF_LSR = 32'h14;
    localparam logic [1:0]  HT_IDLE = 2'b00;
    localparam logic [1:0]  HT_NSEQ = 2'b10;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          in_run;
    logic [CW-1:0] credit;
    logic [CW-1:0] credit_dec;
    logic [7:0]    data_reg;
    logic          data_phase;
    logic          unused_bits;

    assign full       = (count == LW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign s_ready    = in_run & ~full;
    assign push       = s_valid & s_ready;
    // the head leaves the FIFO exactly when the THR address phase is accepted
    assign pop        = (state == S_WR_A) & HREADY & ~empty;
    assign fifo_level = count;
    assign credit_dec = credit - CW'(1);

    assign HSIZE      = 3'b010;
    assign HBURST     = 3'b000;
    assign HPROT      = 4'b0011;
    assign HMASTLOCK  = 1'b0;
    assign HWDATA     = {24'h0, data_reg};

`ifdef UART_FEEDER_INIT_EN
    logic [1:0]  init_idx;
    logic [31:0] init_off;
    logic [7:0]  init_byte;

    assign data_phase  = (state == S_POLL_D) | (state == S_WR_D) | (state == S_INIT_D);
    assign busy        = ((state != S_IDLE) & (state != S_BOOT)) | ~empty;
    assign unused_bits = ^{HRDATA[31:6], HRDATA[4:0]};

    // LCR/DLL/DLM programming sequence: open divisor latch, load divisor, close latch with 8N1
    always_comb begin
        init_off  = 32'h0C;
        init_byte = 8'h83;
        case (init_idx)
            2'd0: begin init_off = 32'h0C; init_byte = 8'h83;          end
            2'd1: begin init_off = 32'h00; init_byte = DIVISOR[7:0];   end
            2'd2: begin init_off = 32'h04; init_byte = DIVISOR[15:8];  end
            default: begin init_off = 32'h0C; init_byte = 8'h03;       end
        endcase
    end

    // step through the four init writes, one per completed data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            init_idx <= 2'd0;
        end else if ((state == S_INIT_D) && HREADY) begin
            init_idx <= init_idx + 2'd1;
        end
    end
`else
    assign data_phase  = (state == S_POLL_D) | (state == S_WR_D);
    assign busy        = (state != S_IDLE) | ~empty;
    assign unused_bits = ^{HRDATA[31:6], HRDATA[4:0], DIVISOR};
`endif

    // address-phase outputs are a pure function of the state so they hold through wait states
    always_comb begin
        HTRANS = HT_IDLE;
        HADDR  = 32'h0;
        HWRITE = 1'b0;
        case (state)
            S_POLL_A: begin HTRANS = HT_NSEQ; HADDR = UART_BASE + OFF_LSR; end
            S_POLL_D: begin HADDR = UART_BASE + OFF_LSR; end
            S_WR_A:   begin HTRANS = HT_NSEQ; HADDR = UART_BASE; HWRITE = 1'b1; end
            S_WR_D:   begin HADDR = UART_BASE; HWRITE = 1'b1; end
`ifdef UART_FEEDER_INIT_EN
            S_INIT_A: begin HTRANS = HT_NSEQ; HADDR = UART_BASE + init_off; HWRITE = 1'b1; end
            S_INIT_D: begin HADDR = UART_BASE + init_off; HWRITE = 1'b1; end
`endif
            default:  begin HTRANS = HT_IDLE; end
        endcase
    end

    // next-state logic: single outstanding transfer, each A phase followed by its D phase
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!empty) state_nxt = S_POLL_A;
            S_POLL_A: if (HREADY) state_nxt = S_POLL_D;
            S_POLL_D: begin
                if (HREADY) begin
                    if (HRESP)          state_nxt = S_POLL_A;
                    else if (HRDATA[5]) state_nxt = S_WR_A;
                    else                state_nxt = S_POLL_A;
                end
            end
            S_WR_A:   if (HREADY) state_nxt = S_WR_D;
            S_WR_D: begin
                if (HREADY) begin
                    if (empty)                 state_nxt = S_IDLE;
                    else if (credit_dec != '0) state_nxt = S_WR_A;
                    else                       state_nxt = S_POLL_A;
                end
            end
`ifdef UART_FEEDER_INIT_EN
            S_BOOT:   state_nxt = S_INIT_A;
            S_INIT_A: if (HREADY) state_nxt = S_INIT_D;
            S_INIT_D: if (HREADY) state_nxt = (init_idx == 2'd3) ? S_IDLE : S_INIT_A;
`endif
            default:  state_nxt = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= S_RESET;
        else          state <= state_nxt;
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + LW'(1);
            else if (pop && !push) count <= count - LW'(1);
        end
    end

    // keep s_ready low while in reset and raise it on the first clock afterwards
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) in_run <= 1'b0;
        else          in_run <= 1'b1;
    end

    // burst credit: reloaded on THRE=1, spent one per completed THR write
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            credit <= '0;
        end else if ((state == S_POLL_D) && HREADY && !HRESP && HRDATA[5]) begin
            credit <= CW'(BURST_MAX);
        end else if ((state == S_WR_D) && HREADY) begin
            credit <= credit_dec;
        end
    end

    // write data register, loaded at address acceptance so HWDATA is stable for the whole data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_reg <= 8'h00;
        end else if (pop) begin
            data_reg <= mem[rd_ptr];
`ifdef UART_FEEDER_INIT_EN
        end else if ((state == S_INIT_A) && HREADY) begin
            data_reg <= init_byte;
`endif
        end
    end

    // sticky bus error flag
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)               err <= 1'b0;
        else if (data_phase && HRESP) err <= 1'b1;
    end

endmodule

// File: tb/tb_ahb_lite_uart_tx_feeder.sv
// tb/tb_ahb_lite_uart_tx_feeder.sv - scoreboard bench for ahb_lite_uart_tx_feeder with an AHB slave model
module tb_ahb_lite_uart_tx_feeder;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = 32'h0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic [4:0]  fifo_level;
    logic        busy;
    logic        err;

    ahb_lite_uart_tx_feeder dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .fifo_level(fifo_level), .busy(busy), .err(err)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] lsr_q[$];
    logic [31:0] lsr_default = 32'h60;
    int          tests = 0;
    int          fails = 0;
    int          wr_wait = 0;
    logic        stall = 1'b0;
    logic        err_next_write = 1'b0;

    logic        dp_active = 1'b0;
    logic        dp_write = 1'b0;
    logic        dp_err = 1'b0;
    logic [31:0] dp_addr = 32'h0;
    logic [7:0]  dp_data = 8'h0;
    int          wait_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic exp_rd();
        exp_t e;
        e.w = 1'b0; e.a = 32'h14; e.d = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [7:0] d);
        exp_t e;
        e.w = 1'b1; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_init();
`ifdef UART_FEEDER_INIT_EN
        exp_wr(32'h0C, 8'h83);
        exp_wr(32'h00, 8'h1B);
        exp_wr(32'h04, 8'h00);
        exp_wr(32'h0C, 8'h03);
`endif
    endtask

    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge HCLK);
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 2000) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= 2000) timeout_fail("push_wait");
        @(posedge HCLK);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge HCLK);
        while ((exp_q.size() != 0 || busy || dp_active) && n < 3000) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= 3000) timeout_fail(name);
    endtask

    // AHB slave model and scoreboard monitor: pops an expectation at every accepted address phase
    always @(posedge HCLK) begin
        exp_t e;
        #1;
        if (!HRESETn) begin
            dp_active = 1'b0;
            HREADY = 1'b1;
            HRESP = 1'b0;
            HRDATA = 32'h0;
        end else if (dp_active) begin
            if (wait_left > 0) begin
                wait_left--;
                HREADY = 1'b0;
                HRESP = 1'b0;
                if (dp_write) begin
                    chk("hold_haddr", HADDR, dp_addr);
                    chk("hold_hwdata", HWDATA, {24'h0, dp_data});
                    chk("hold_hwrite", {31'h0, HWRITE}, 32'h1);
                end
            end else begin
                HREADY = 1'b1;
                HRESP = dp_err;
                chk("dp_htrans_idle", {30'h0, HTRANS}, 32'h0);
                if (dp_write) chk("thr_data", HWDATA, {24'h0, dp_data});
                else HRDATA = (lsr_q.size() > 0) ? lsr_q.pop_front() : lsr_default;
                dp_active = 1'b0;
            end
        end else begin
            HRESP = 1'b0;
            HRDATA = 32'h0;
            HREADY = ~stall;
            if (HTRANS == 2'b10 && !stall) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_xfer: got addr %h write %0d, required no transfer", HADDR, HWRITE);
                    dp_data = 8'h00;
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_dir", {31'h0, HWRITE}, {31'h0, e.w});
                    chk("xfer_addr", HADDR, e.a);
                    dp_data = e.d;
                end
                dp_active = 1'b1;
                dp_write = HWRITE;
                dp_addr = HADDR;
                wait_left = HWRITE ? wr_wait : 0;
                dp_err = HWRITE & err_next_write;
                if (dp_err) err_next_write = 1'b0;
            end
        end
    end

    initial begin
        int n;
        // reset state
        repeat (3) @(negedge HCLK);
        chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_s_ready", {31'h0, s_ready}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_level", {27'h0, fifo_level}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("hsize", {29'h0, HSIZE}, 32'h2);
        chk("hprot", {28'h0, HPROT}, 32'h3);
        expect_init();
        HRESETn = 1'b1;
        @(posedge HCLK);
        #2 chk("s_ready_after_rst", {31'h0, s_ready}, 32'h1);
        wait_idle("init_done");

        // 1: single byte, LSR=0x60
        lsr_q.push_back(32'h60);
        exp_rd();
        exp_wr(32'h00, 8'h41);
        push(8'h41);
        chk("t1_level_after_push", {27'h0, fifo_level}, 32'h1);
        wait_idle("t1_idle");
        chk("t1_level_end", {27'h0, fifo_level}, 32'h0);
        chk("t1_busy_end", {31'h0, busy}, 32'h0);

        // 2: 20 bytes, burst of 16 then re-poll
        exp_rd();
        for (int i = 0; i < 16; i++) exp_wr(32'h00, 8'(8'h30 + i));
        exp_rd();
        for (int i = 16; i < 20; i++) exp_wr(32'h00, 8'(8'h30 + i));
        for (int i = 0; i < 20; i++) push(8'(8'h30 + i));
        wait_idle("t2_idle");

        // 3: THRE=0 for five polls
        for (int i = 0; i < 5; i++) lsr_q.push_back(32'h00);
        lsr_q.push_back(32'h20);
        for (int i = 0; i < 6; i++) exp_rd();
        exp_wr(32'h00, 8'hC3);
        push(8'hC3);
        wait_idle("t3_idle");

        // 4: three wait states on each write
        wr_wait = 3;
        exp_rd();
        exp_wr(32'h00, 8'hA5);
        exp_wr(32'h00, 8'h5A);
        push(8'hA5);
        push(8'h5A);
        wait_idle("t4_idle");
        wr_wait = 0;
        chk("t4_level_end", {27'h0, fifo_level}, 32'h0);

        // 5: fill the FIFO while the bus is held, then drain
        stall = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        @(negedge HCLK);
        chk("t5_full_s_ready", {31'h0, s_ready}, 32'h0);
        chk("t5_full_level", {27'h0, fifo_level}, 32'h10);
        s_valid = 1'b1;
        s_data = 8'hEE;
        repeat (3) @(negedge HCLK);
        s_valid = 1'b0;
        chk("t5_ignored_push", {27'h0, fifo_level}, 32'h10);
        lsr_q.push_back(32'h00);
        lsr_q.push_back(32'h00);
        exp_rd(); exp_rd(); exp_rd();
        for (int i = 0; i < 16; i++) exp_wr(32'h00, 8'(8'h80 + i));
        stall = 1'b0;
        n = 0;
        while (fifo_level != 5'd15 && n < 200) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= 200) timeout_fail("t5_first_pop");
        chk("t5_s_ready_after_pop", {31'h0, s_ready}, 32'h1);
        wait_idle("t5_idle");

        // 6a: error response on a THR write; next byte still follows
        err_next_write = 1'b1;
        exp_rd();
        exp_wr(32'h00, 8'h77);
        exp_wr(32'h00, 8'h78);
        push(8'h77);
        push(8'h78);
        wait_idle("t6a_idle");
        chk("t6a_err_sticky", {31'h0, err}, 32'h1);

        // 6b: reset in the middle of a write data phase
        wr_wait = 20;
        exp_rd();
        exp_wr(32'h00, 8'h99);
        push(8'h99);
        n = 0;
        while (!(dp_active && dp_write) && n < 200) begin
            @(negedge HCLK);
            n++;
        end
        if (n >= 200) timeout_fail("t6b_reach_wr_d");
        HRESETn = 1'b0;
        #1;
        chk("t6b_htrans", {30'h0, HTRANS}, 32'h0);
        chk("t6b_haddr", HADDR, 32'h0);
        chk("t6b_hwdata", HWDATA, 32'h0);
        chk("t6b_level", {27'h0, fifo_level}, 32'h0);
        chk("t6b_err", {31'h0, err}, 32'h0);
        chk("t6b_s_ready", {31'h0, s_ready}, 32'h0);
        exp_q.delete();
        lsr_q.delete();
        wr_wait = 0;
        @(negedge HCLK);
        expect_init();
        HRESETn = 1'b1;
        wait_idle("t6b_reinit");

        // traffic resumes after reset
        exp_rd();
        exp_wr(32'h00, 8'h5C);
        push(8'h5C);
        wait_idle("t6b_resume");
        chk("final_err", {31'h0, err}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
